// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core.
// Handles the EX redirect, hazard-unit holds, imem wait states and perf counters.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             stall_pc,
    input  logic             stall_id,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic [31:0]      imem_instr,
    input  logic             imem_ready,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_ID,
    output logic [31:0]      pc4_ID,
    output logic [31:0]      instr_ID,
    output logic             valid_ID,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [31:0]      r_pc;
    logic [31:0]      r_pc_id;
    logic [31:0]      r_pc4_id;
    logic [31:0]      r_instr_id;
    logic             r_valid_id;
    logic             r_misalign;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [31:0]      w_pc4;
    logic             w_bubble;

    assign w_pc4    = r_pc + 32'd4;
    // A flush always bubbles; a missing fetch bubbles only when ID is not held.
    assign w_bubble = br_taken | (~stall_id & ~imem_ready);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (br_taken) begin
            r_pc <= {br_target[31:2], 2'b00};
        end else if (!stall_pc && imem_ready) begin
            r_pc <= w_pc4;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= 32'd0;
            r_pc4_id   <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (w_bubble) begin
            r_instr_id <= NOP_INSTR;
            r_valid_id <= 1'b0;
        end else if (!stall_id) begin
            r_instr_id <= imem_instr;
            r_pc_id    <= r_pc;
            r_pc4_id   <= w_pc4;
            r_valid_id <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_misalign <= 1'b0;
        end else if (br_taken && (br_target[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (stall_pc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign pc_ID        = r_pc_id;
    assign pc4_ID       = r_pc4_id;
    assign instr_ID     = r_instr_id;
    assign valid_ID     = r_valid_id;
    assign misalign_err = r_misalign;
    assign stall_cnt    = r_stall_cnt;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: behavioural model checked every cycle plus
// directed vectors with hand-computed literal expectations.
module tb_fetch_ifid_stage;

    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = 15;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic             clk;
    logic             rstN;
    logic             stallPc;
    logic             stallId;
    logic             brTaken;
    logic [31:0]      brTarget;
    logic [31:0]      imemInstr;
    logic             imemReady;
    logic [31:0]      imemAddr;
    logic [31:0]      pcId;
    logic [31:0]      pc4Id;
    logic [31:0]      instrId;
    logic             validId;
    logic             misalignErr;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] bubbleCnt;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    // Model state
    logic [31:0] mPc;
    logic [31:0] mPcId;
    logic [31:0] mPc4Id;
    logic [31:0] mInstr;
    logic        mValid;
    logic        mMis;
    int          mStall;
    int          mBubble;

    fetch_ifid_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .stall_pc     (stallPc),
        .stall_id     (stallId),
        .br_taken     (brTaken),
        .br_target    (brTarget),
        .imem_instr   (imemInstr),
        .imem_ready   (imemReady),
        .imem_addr    (imemAddr),
        .pc_ID        (pcId),
        .pc4_ID       (pc4Id),
        .instr_ID     (instrId),
        .valid_ID     (validId),
        .misalign_err (misalignErr),
        .stall_cnt    (stallCnt),
        .bubble_cnt   (bubbleCnt)
    );

    function automatic logic [31:0] memInstr(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hBEEF, addr[15:0]};
    endfunction

    assign imemInstr = memInstr(imemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: next state from the priority rules, using plain arithmetic.
    always @(posedge clk) begin
        if (!rstN) begin
            mPc = 32'd0; mPcId = 32'd0; mPc4Id = 32'd0; mInstr = NOP;
            mValid = 1'b0; mMis = 1'b0; mStall = 0; mBubble = 0;
        end else begin
            if (brTaken || (!stallId && !imemReady)) begin
                mInstr  = NOP;
                mValid  = 1'b0;
                mBubble = (mBubble + 1 > CNT_MAX) ? CNT_MAX : mBubble + 1;
            end else if (!stallId) begin
                mInstr = memInstr(mPc);
                mPcId  = mPc;
                mPc4Id = mPc + 32'd4;
                mValid = 1'b1;
            end
            if (stallPc) mStall = (mStall + 1 > CNT_MAX) ? CNT_MAX : mStall + 1;
            if (brTaken && (brTarget % 4 != 0)) mMis = 1'b1;
            if (brTaken) mPc = brTarget - (brTarget % 4);
            else if (!stallPc && imemReady) mPc = mPc + 32'd4;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("m_imem_addr", imemAddr, mPc);
            checkOutput("m_pc_ID", pcId, mPcId);
            checkOutput("m_pc4_ID", pc4Id, mPc4Id);
            checkOutput("m_instr_ID", instrId, mInstr);
            checkOutput("m_valid_ID", {31'd0, validId}, {31'd0, mValid});
            checkOutput("m_misalign", {31'd0, misalignErr}, {31'd0, mMis});
            checkOutput("m_stall_cnt", {28'd0, stallCnt}, mStall);
            checkOutput("m_bubble_cnt", {28'd0, bubbleCnt}, mBubble);
        end
    end

    task automatic applyStimulus(input logic rst, input logic sp, input logic sid, input logic bt,
                                 input logic [31:0] tgt, input logic rdy, input int n);
        rstN = rst; stallPc = sp; stallId = sid; brTaken = bt; brTarget = tgt; imemReady = rdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0; stallPc = 1'b0; stallId = 1'b0; brTaken = 1'b0;
        brTarget = 32'd0; imemReady = 1'b1;
        @(negedge clk);

        applyStimulus(0, 0, 0, 0, 32'h0, 1, 2);
        checkEn = 1;
        checkOutput("rst_pc", imemAddr, 32'h0);
        checkOutput("rst_instr", instrId, NOP);
        checkOutput("rst_valid", {31'd0, validId}, 32'd0);
        checkOutput("rst_stall_cnt", {28'd0, stallCnt}, 32'd0);

        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        checkOutput("seq_pc1", imemAddr, 32'h4);
        checkOutput("seq_instr1", instrId, 32'hBEEF_0000);
        checkOutput("seq_valid1", {31'd0, validId}, 32'd1);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        checkOutput("seq_pc2", imemAddr, 32'h8);
        checkOutput("seq_pcid2", pcId, 32'h4);
        checkOutput("seq_pc4id2", pc4Id, 32'h8);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 2);
        checkOutput("seq_pc4", imemAddr, 32'h10);

        applyStimulus(1, 1, 1, 0, 32'h0, 1, 3);
        checkOutput("stall_pc_hold", imemAddr, 32'h10);
        checkOutput("stall_pcid_hold", pcId, 32'hC);
        checkOutput("stall_cnt3", {28'd0, stallCnt}, 32'd3);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        checkOutput("release_pc", imemAddr, 32'h14);
        checkOutput("release_pcid", pcId, 32'h10);

        applyStimulus(1, 0, 1, 1, 32'h100, 1, 1);
        checkOutput("flush_pc", imemAddr, 32'h100);
        checkOutput("flush_instr", instrId, NOP);
        checkOutput("flush_valid", {31'd0, validId}, 32'd0);
        checkOutput("flush_bubble", {28'd0, bubbleCnt}, 32'd1);
        checkOutput("flush_pcid_hold", pcId, 32'h10);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        checkOutput("after_flush_pcid", pcId, 32'h100);

        applyStimulus(1, 0, 0, 1, 32'h20, 1, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 2);
        checkOutput("wait_pc", imemAddr, 32'h20);
        checkOutput("wait_bubble", {28'd0, bubbleCnt}, 32'd4);
        applyStimulus(1, 1, 1, 0, 32'h0, 0, 1);
        checkOutput("stall_wait_bubble", {28'd0, bubbleCnt}, 32'd4);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        checkOutput("ready_pcid", pcId, 32'h20);
        checkOutput("ready_instr", instrId, 32'hBECF_0020);
        checkOutput("ready_pc", imemAddr, 32'h24);

        applyStimulus(1, 0, 0, 1, 32'h203, 0, 1);
        checkOutput("mis_pc", imemAddr, 32'h200);
        checkOutput("mis_err", {31'd0, misalignErr}, 32'd1);
        checkOutput("mis_bubble", {28'd0, bubbleCnt}, 32'd5);
        applyStimulus(1, 0, 0, 1, 32'h300, 1, 1);
        checkOutput("mis_sticky", {31'd0, misalignErr}, 32'd1);

        applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 1);
        checkOutput("wrap_pre", imemAddr, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        checkOutput("wrap_pc", imemAddr, 32'h0);
        checkOutput("wrap_pc4id", pc4Id, 32'h0);

        applyStimulus(1, 1, 0, 0, 32'h0, 1, 20);
        checkOutput("sat_stall_cnt", {28'd0, stallCnt}, 32'd15);
        checkOutput("dup_pcid", pcId, 32'h0);
        checkOutput("dup_valid", {31'd0, validId}, 32'd1);

        applyStimulus(0, 1, 0, 1, 32'h43, 1, 1);
        checkOutput("midrst_pc", imemAddr, 32'h0);
        checkOutput("midrst_pc4id", pc4Id, 32'h0);
        checkOutput("midrst_instr", instrId, NOP);
        checkOutput("midrst_mis", {31'd0, misalignErr}, 32'd0);
        checkOutput("midrst_stall", {28'd0, stallCnt}, 32'd0);
        checkOutput("midrst_bubble", {28'd0, bubbleCnt}, 32'd0);

        applyStimulus(1, 0, 0, 0, 32'h0, 1, 2);
        checkOutput("post_rst_pc", imemAddr, 32'h8);

        @(negedge clk);
        checkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the non-forwarding 5-stage RV32I core.
- Sits directly upstream of the ID-stage hazard detector and feeds it instr_ID.
- Consumes that detector's stall outputs, both active-high hold signals: stall_pc on enable_pc and stall_id on enable_ID.
- Also consumes the EX-stage branch/jump redirect and drives the instruction-memory address.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) injected into IF/ID.
- CNT_W, 16, width of the saturating stall/bubble performance counters.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- stall_pc  in  1  hazard unit hold request for PC (1 = hold).
- stall_id  in  1  hazard unit hold request for IF/ID (1 = hold).
- br_taken  in  1  EX-stage redirect valid (taken branch, jal, jalr).
- br_target  in  32  EX-stage redirect address.
- imem_instr  in  32  instruction word at imem_addr, combinational read.
- imem_ready  in  1  imem_instr valid this cycle.
- imem_addr  out  32  current PC, driven combinationally from the PC register.
- pc_ID  out  32  PC of the instruction in ID.
- pc4_ID  out  32  pc_ID + 4.
- instr_ID  out  32  instruction in ID (to decoder and hazard unit).
- valid_ID  out  1  1 = instr_ID is a real instruction; 0 = bubble.
- misalign_err  out  1  sticky: a redirect target had br_target[1:0] != 0.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted into IF/ID.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): PC=RESET_PC, instr_ID=NOP_INSTR, pc_ID=0, pc4_ID=0, valid_ID=0, misalign_err=0, stall_cnt=0, bubble_cnt=0. Reset overrides every other input, including mid-stall and mid-redirect.
- imem_addr = PC. There is no registered request, so fetch latency is 0 cycles to imem and 1 cycle to the ID register.
- Next-PC priority (highest first):
  - br_taken: PC <= {br_target[31:2],2'b00}.
  - stall_pc: PC holds.
  - !imem_ready: PC holds.
  - otherwise: PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- IF/ID priority (highest first):
  - br_taken: load bubble (instr_ID=NOP_INSTR, valid_ID=0; pc_ID/pc4_ID hold). The flush wins over stall_id because the ID occupant is on the wrong path.
  - stall_id: all IF/ID fields hold, including valid_ID.
  - imem_ready=1: instr_ID<=imem_instr, pc_ID<=PC, pc4_ID<=PC+4, valid_ID<=1.
  - imem_ready=0: load bubble.
- Stall-while-not-ready: stall_pc and stall_id take precedence, so no bubble is counted.
- Redirect during a memory wait: the redirect is applied; the not-ready fetch is discarded.
- misalign_err is set on any cycle with br_taken=1 and br_target[1:0]!=0, and clears only on reset. The low two bits are forced to 0 in the loaded PC.
- stall_cnt increments on each cycle with stall_pc=1 and holds at 2^CNT_W-1.
- bubble_cnt increments on each cycle a bubble is loaded into IF/ID (flush or not-ready) and saturates the same way.
- Both counters are frozen during reset and cleared by it.
- stall_pc=1 with stall_id=0 (not produced by the current hazard unit): PC holds and IF/ID reloads the same PC's instruction, i.e. a duplicate fetch. This is legal and defined by the priority lists above.

Test Plan:
- Reset then 4 cycles with imem_ready=1 and no stall -> imem_addr 0,4,8,12. pc_ID follows one cycle later. valid_ID=1 from cycle 2 on.
- PC=0x10 with stall_pc=stall_id=1 for 3 cycles -> imem_addr stays 0x10 and instr_ID/pc_ID are unchanged. On release, the next cycle shows PC=0x14 and pc_ID=0x10. stall_cnt=3.
- br_taken=1, br_target=0x100, with stall_id=1 in the same cycle -> next cycle PC=0x100, instr_ID=0x00000013, valid_ID=0, bubble_cnt+1.
- imem_ready=0 for 2 cycles at PC=0x20 -> PC holds 0x20 and 2 bubbles enter ID (bubble_cnt+2). Ready returns -> instr at 0x20 reaches ID.
- br_target=0x203 -> PC=0x200 and misalign_err=1, which stays 1 through further redirects until i_rst_n=0.
- CNT_W=4 with stall_pc held 20 cycles -> stall_cnt saturates at 15. Assert i_rst_n=0 mid-stall -> all outputs return to reset values on the next edge.
